snow64_memory_bus_arbiter: RTL

SNOW64_MEMORY_BUS_ARBITER -- requirements
Module: snow64_memory_bus_arbiter

---
 rtl/snow64_memory_bus_arbiter_if.sv | 34 +++
 rtl/snow64_memory_bus_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/snow64_memory_bus_arbiter_if.sv
// Bus bundle between requester channels, the arbiter and the memory port.
// The arbiter takes the slave view; requesters and memory (or a bench) take the master view.
interface snow64_memory_bus_arbiter_if #(
  parameter int NUM_CHANNELS = 3,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 256
);
  logic [NUM_CHANNELS-1:0]            in_req;
  logic [NUM_CHANNELS-1:0]            in_is_write;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] in_addr;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_wdata;
  logic [NUM_CHANNELS-1:0]            out_cmd_accepted;
  logic [NUM_CHANNELS-1:0]            out_valid;
  logic                               out_err;
  logic [DATA_WIDTH-1:0]              out_rdata;
  logic                               mem_req;
  logic [ADDR_WIDTH-1:0]              mem_addr;
  logic [DATA_WIDTH-1:0]              mem_wdata;
  logic                               mem_acc_type;
  logic                               mem_valid;
  logic [DATA_WIDTH-1:0]              mem_rdata;

  modport slave (
    input  in_req, in_is_write, in_addr, in_wdata, mem_valid, mem_rdata,
    output out_cmd_accepted, out_valid, out_err, out_rdata,
           mem_req, mem_addr, mem_wdata, mem_acc_type
  );

  modport master (
    output in_req, in_is_write, in_addr, in_wdata, mem_valid, mem_rdata,
    input  out_cmd_accepted, out_valid, out_err, out_rdata,
           mem_req, mem_addr, mem_wdata, mem_acc_type
  );
endinterface

// File: rtl/snow64_memory_bus_arbiter.sv
// Arbitrates NUM_CHANNELS requesters onto a single memory port, one command
// in flight at a time, with a wait timeout that completes the command with err.
module snow64_memory_bus_arbiter #(
  parameter int NUM_CHANNELS   = 3,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 256,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst_n,
  snow64_memory_bus_arbiter_if.slave bus
);
  localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWaitMem, StRespond} StateT;

  StateT state, nextState;

  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] chAddr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] chWdata;

  logic [PW-1:0]         grantIdx;
  logic                  anyReq;
  logic [PW-1:0]         gReg;
  logic [PW-1:0]         ptr;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [DATA_WIDTH-1:0] wdataReg;
  logic                  typeReg;
  logic [DATA_WIDTH-1:0] rdataReg;
  logic                  errFlag;
  logic                  timeoutHit;

  assign chAddr     = bus.in_addr;
  assign chWdata    = bus.in_wdata;
  assign timeoutHit = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Pick the winning channel: rotating search from ptr, or lowest index in fixed mode.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    grantIdx = '0;
    anyReq   = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (ROUND_ROBIN != 0) idx = PW'((int'(ptr) + k) % NUM_CHANNELS);
      else                  idx = PW'(k);
      if (!anyReq && bus.in_req[idx]) begin
        anyReq   = 1'b1;
        grantIdx = idx;
      end
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= StIdle;
    else        state <= nextState;
  end

  // Next-state: memory completion wins over a coincident timeout.
  always_comb begin
    nextState = state;
    case (state)
      StIdle:    if (anyReq) nextState = StWaitMem;
      StWaitMem: if (bus.mem_valid || timeoutHit) nextState = StRespond;
      StRespond: nextState = StIdle;
      default:   nextState = StIdle;
    endcase
  end

  // Command capture, rotation pointer, timeout counter and response data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gReg     <= '0;
      ptr      <= '0;
      cnt      <= '0;
      addrReg  <= '0;
      wdataReg <= '0;
      typeReg  <= 1'b0;
      rdataReg <= '0;
      errFlag  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (anyReq) begin
            gReg     <= grantIdx;
            addrReg  <= chAddr[grantIdx];
            wdataReg <= chWdata[grantIdx];
            typeReg  <= bus.in_is_write[grantIdx];
            cnt      <= '0;
            if (ROUND_ROBIN != 0)
              ptr <= (grantIdx == PW'(NUM_CHANNELS - 1)) ? '0 : grantIdx + 1'b1;
          end
        end
        StWaitMem: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_valid) begin
            rdataReg <= bus.mem_rdata;
            errFlag  <= 1'b0;
          end else if (timeoutHit) begin
            errFlag  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state; the accept pulse is the first WaitMem cycle (cnt still 0).
  always_comb begin
    bus.out_cmd_accepted = '0;
    bus.out_valid        = '0;
    bus.mem_req          = (state == StWaitMem);
    bus.out_err          = (state == StRespond) && errFlag;
    bus.out_rdata        = rdataReg;
    bus.mem_addr         = addrReg;
    bus.mem_wdata        = wdataReg;
    bus.mem_acc_type     = typeReg;
    if (state == StWaitMem && cnt == '0) bus.out_cmd_accepted[gReg] = 1'b1;
    if (state == StRespond)              bus.out_valid[gReg]        = 1'b1;
  end
endmodule
